cf_div_iter: RTL and testbench

CF_DIV_ITER -- requirements
Module: cf_div_iter

---
 rtl/cf_math_pkg.sv | 15 +
 rtl/cf_div_iter_cnt.sv | 35 +++
 rtl/cf_div_iter.sv | 142 ++++++++++++++
 tb/tb_cf_div_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cf_math_pkg.sv
// Shared arithmetic types and helpers used by the iterative divider.
// Provides the rounding-mode enum and the index-width helper.
package cf_math_pkg;

    typedef enum logic {
        DivFloor = 1'b0,
        DivCeil  = 1'b1
    } div_mode_e;

    // Bits needed to index num_idx items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/cf_div_iter_cnt.sv
// Up-counter cell with synchronous clear and enable.
// Used by cf_div_iter to count restoring-division steps.
module cf_div_iter_cnt #(
    parameter int unsigned CntWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                en_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cf_div_iter.sv
// Iterative radix-2 restoring divider with floor/ceil rounding, one quotient bit per cycle.
// Optional divide-by-zero flag enabled by defining CF_DIV_ITER_DIV_ZERO_EN.
module cf_div_iter
    import cf_math_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned CntWidth = cf_math_pkg::idx_width(Width)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    input  div_mode_e        mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [Width-1:0]    quo_q, quo_d;
    logic [Width-1:0]    rem_q, rem_d;
    logic [Width-1:0]    divisor_q, divisor_d;
    div_mode_e           mode_q, mode_d;
    logic [Width-1:0]    res_quo_q, res_quo_d;
    logic [Width-1:0]    res_rem_q, res_rem_d;
    logic                ready_en_q;
    logic [CntWidth-1:0] cnt;

    logic [Width:0]      shifted, trial;
    logic                step_bit, ceil_adj, last_step;
    logic [Width-1:0]    step_quo, step_rem;

    cf_div_iter_cnt #(
        .CntWidth (CntWidth)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_q != BUSY),
        .en_i    (state_q == BUSY),
        .cnt_o   (cnt)
    );

    assign last_step = (cnt == CntWidth'(Width - 1));

    // A divisor of zero never borrows, so the quotient fills with ones and the remainder
    // rebuilds the dividend; the ceil fix-up is skipped for an all-ones quotient.
    always_comb begin
        shifted  = {rem_q, quo_q[Width-1]};
        trial    = shifted - {1'b0, divisor_q};
        step_bit = ~trial[Width];
        step_rem = step_bit ? trial[Width-1:0] : shifted[Width-1:0];
        step_quo = {quo_q[Width-2:0], step_bit};
        ceil_adj = (mode_q == DivCeil) && (step_rem != '0) && (step_quo != '1);
    end

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        mode_d    = mode_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        unique case (state_q)
            IDLE: begin
                if (!flush_i && valid_i && ready_en_q) begin
                    quo_d     = dividend_i;
                    rem_d     = '0;
                    divisor_d = divisor_i;
                    mode_d    = mode_i;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    if (last_step) begin
                        res_quo_d = ceil_adj ? step_quo + Width'(1) : step_quo;
                        res_rem_d = ceil_adj ? divisor_q - step_rem : step_rem;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (flush_i || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            mode_q     <= DivFloor;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            mode_q     <= mode_d;
            res_quo_q  <= res_quo_d;
            res_rem_q  <= res_rem_d;
            ready_en_q <= 1'b1;
        end
    end

    assign ready_o     = (state_q == IDLE) && ready_en_q;
    assign valid_o     = (state_q == DONE);
    assign quotient_o  = res_quo_q;
    assign remainder_o = res_rem_q;

`ifdef CF_DIV_ITER_DIV_ZERO_EN
    assign div_zero_o = (state_q == DONE) && (divisor_q == '0);
`else
    assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_cf_div_iter.sv
// Directed self-checking bench for cf_div_iter at Width = 8.
// Honours CF_DIV_ITER_DIV_ZERO_EN for the expected divide-by-zero flag.
module tb_cf_div_iter;
    import cf_math_pkg::*;

    localparam int unsigned W = 8;
`ifdef CF_DIV_ITER_DIV_ZERO_EN
    localparam logic DzEn = 1'b1;
`else
    localparam logic DzEn = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    div_mode_e    mode_i = DivFloor;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    cf_div_iter #(
        .Width (W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .mode_i      (mode_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a request; operands are scrambled right after the accepting edge.
    task automatic start(input logic [W-1:0] n, input logic [W-1:0] d, input div_mode_e m);
        int guard = 0;
        while (!ready_o && guard < 50) begin
            tick();
            guard++;
        end
        check("ready before request", 32'(ready_o), 32'd1);
        valid_i    = 1'b1;
        dividend_i = n;
        divisor_i  = d;
        mode_i     = m;
        tick();
        valid_i    = 1'b0;
        dividend_i = 8'hA5;
        divisor_i  = 8'h3C;
        mode_i     = (m == DivFloor) ? DivCeil : DivFloor;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!valid_o && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(W));
    endtask

    task automatic run(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                       input div_mode_e m, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz);
        start(n, d, m);
        wait_done(tag);
        check({tag, " quotient"}, 32'(quotient_o), 32'(eq));
        check({tag, " remainder"}, 32'(remainder_o), 32'(er));
        check({tag, " div_zero"}, 32'(div_zero_o), 32'(edz));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({tag, " valid dropped"}, 32'(valid_o), 32'd0);
        check({tag, " ready back"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_valid;

        // Reset state
        #1;
        check("reset ready", 32'(ready_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset quotient", 32'(quotient_o), 32'd0);
        check("reset remainder", 32'(remainder_o), 32'd0);
        check("reset div_zero", 32'(div_zero_o), 32'd0);
        #11;
        rst_ni = 1'b1;
        #1;
        check("ready before first edge", 32'(ready_o), 32'd0);
        tick();
        check("ready after first edge", 32'(ready_o), 32'd1);

        // Basic and boundary operations
        run("7/2 floor", 8'd7, 8'd2, DivFloor, 8'd3, 8'd1, 1'b0);
        run("7/2 ceil", 8'd7, 8'd2, DivCeil, 8'd4, 8'd1, 1'b0);
        run("200/10 ceil", 8'd200, 8'd10, DivCeil, 8'd20, 8'd0, 1'b0);
        run("0/5 ceil", 8'd0, 8'd5, DivCeil, 8'd0, 8'd0, 1'b0);
        run("0/5 floor", 8'd0, 8'd5, DivFloor, 8'd0, 8'd0, 1'b0);
        run("5/0 floor", 8'd5, 8'd0, DivFloor, 8'd255, 8'd5, DzEn);
        run("5/0 ceil", 8'd5, 8'd0, DivCeil, 8'd255, 8'd5, DzEn);
        run("1/255 ceil", 8'd1, 8'd255, DivCeil, 8'd1, 8'd254, 1'b0);
        run("255/2 ceil", 8'd255, 8'd2, DivCeil, 8'd128, 8'd1, 1'b0);
        run("13/13 ceil", 8'd13, 8'd13, DivCeil, 8'd1, 8'd0, 1'b0);
        run("250/7 floor", 8'd250, 8'd7, DivFloor, 8'd35, 8'd5, 1'b0);

        // Back-pressure: result held while ready_i is low
        start(8'd255, 8'd1, DivFloor);
        wait_done("255/1 floor");
        for (int i = 0; i < 5; i++) begin
            check("hold valid", 32'(valid_o), 32'd1);
            check("hold quotient", 32'(quotient_o), 32'd255);
            check("hold remainder", 32'(remainder_o), 32'd0);
            check("hold ready low", 32'(ready_o), 32'd0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("ready after hold", 32'(ready_o), 32'd1);

        // Flush during BUSY cycle 3: no result
        start(8'd50, 8'd3, DivFloor);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen_valid |= valid_o;
            tick();
        end
        check("flush busy no valid", 32'(seen_valid), 32'd0);
        check("flush busy ready", 32'(ready_o), 32'd1);

        // Flush wins over a simultaneous request
        flush_i    = 1'b1;
        valid_i    = 1'b1;
        dividend_i = 8'd40;
        divisor_i  = 8'd4;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush+valid not accepted", 32'(ready_o), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen_valid |= valid_o;
            tick();
        end
        check("flush+valid no result", 32'(seen_valid), 32'd0);

        run("9/4 ceil", 8'd9, 8'd4, DivCeil, 8'd3, 8'd3, 1'b0);

        // Flush in DONE discards the result
        start(8'd20, 8'd6, DivFloor);
        wait_done("flush done");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush done valid", 32'(valid_o), 32'd0);
        check("flush done ready", 32'(ready_o), 32'd1);

        // Asynchronous reset mid-BUSY
        start(8'd200, 8'd3, DivFloor);
        tick();
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst busy quotient", 32'(quotient_o), 32'd0);
        check("rst busy remainder", 32'(remainder_o), 32'd0);
        check("rst busy valid", 32'(valid_o), 32'd0);
        check("rst busy ready", 32'(ready_o), 32'd0);
        check("rst busy div_zero", 32'(div_zero_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        run("100/7 floor", 8'd100, 8'd7, DivFloor, 8'd14, 8'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
